// File: rtl/traffic_pkg.sv
// Shared types and default timings for the intersection phase scheduler.
// Phase encodings are fixed because they appear on the debug phase output.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALL_RED = 3'd2,
    PED     = 3'd3,
    SIDE_G  = 3'd4,
    SIDE_Y  = 3'd5
  } phase_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } road_lamp_t;

  typedef struct packed {
    road_lamp_t main_l;
    road_lamp_t side_l;
    logic       walk;
  } lamps_t;

  localparam int DEF_CLK_HZ       = 24_000_000;
  localparam int DEF_GREEN_MAIN_S = 30;
  localparam int DEF_GREEN_SIDE_S = 15;
  localparam int DEF_YELLOW_S     = 3;
  localparam int DEF_ALLRED_S     = 2;
  localparam int DEF_PED_S        = 10;

  // Unused encodings fall back to all-red so no road ever sees a stray green.
  function automatic lamps_t lamps_of(input phase_t p);
    lamps_t l;
    l = '0;
    case (p)
      MAIN_G:  begin l.main_l.g = 1'b1; l.side_l.r = 1'b1; end
      MAIN_Y:  begin l.main_l.y = 1'b1; l.side_l.r = 1'b1; end
      SIDE_G:  begin l.side_l.g = 1'b1; l.main_l.r = 1'b1; end
      SIDE_Y:  begin l.side_l.y = 1'b1; l.main_l.r = 1'b1; end
      PED:     begin l.main_l.r = 1'b1; l.side_l.r = 1'b1; l.walk = 1'b1; end
      default: begin l.main_l.r = 1'b1; l.side_l.r = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Prescaler producing a one-cycle strobe every DIV clocks; o_tick_now marks
// the edge on which the strobe register rises, so users can act on that edge.
module traffic_tick_gen #(
  parameter int DIV = 24_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick_now,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_tick;

  assign o_tick_now = (r_cnt == LAST);
  assign o_tick     = r_tick;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= o_tick_now ? '0 : r_cnt + 1'b1;
      r_tick <= o_tick_now;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase scheduler with all-red clearance.
// Define TRAFFIC_PED_EN to include the pedestrian crossing phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int GREEN_MAIN_S = DEF_GREEN_MAIN_S,
  parameter int GREEN_SIDE_S = DEF_GREEN_SIDE_S,
  parameter int YELLOW_S     = DEF_YELLOW_S,
  parameter int ALLRED_S     = DEF_ALLRED_S,
  parameter int PED_S        = DEF_PED_S
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_side_req,
  input  logic       i_ped_req,
  output logic       o_main_r,
  output logic       o_main_y,
  output logic       o_main_g,
  output logic       o_side_r,
  output logic       o_side_y,
  output logic       o_side_g,
  output logic       o_ped_walk,
  output logic       o_ped_ack,
  output logic       o_sec_tick,
  output logic [2:0] o_phase
);

  if (GREEN_MAIN_S < 1 || GREEN_MAIN_S > 255 || GREEN_SIDE_S < 1 || GREEN_SIDE_S > 255 ||
      YELLOW_S < 1 || YELLOW_S > 255 || ALLRED_S < 1 || ALLRED_S > 255 ||
      PED_S < 1 || PED_S > 255) begin : g_bad_duration
    $error("traffic_phase_ctrl: duration parameters must be in 1..255");
  end

  localparam logic [7:0] GM_LAST = 8'(GREEN_MAIN_S - 1);
  localparam logic [7:0] GS_LAST = 8'(GREEN_SIDE_S - 1);
  localparam logic [7:0] Y_LAST  = 8'(YELLOW_S - 1);
  localparam logic [7:0] AR_LAST = 8'(ALLRED_S - 1);
  localparam logic [7:0] P_LAST  = 8'(PED_S - 1);
  localparam lamps_t RESET_LAMPS = lamps_of(ALL_RED);

  logic       w_tick_now;
  logic       w_ped_pend;
  phase_t     w_state_d;
  phase_t     w_nxt_d;
  phase_t     r_state;
  phase_t     r_nxt;
  logic [7:0] r_sec_cnt;
  lamps_t     r_lamps;

  traffic_tick_gen #(.DIV(CLK_HZ)) u_tick (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_tick_now (w_tick_now),
    .o_tick     (o_sec_tick)
  );

  // Next-state decode; durations are measured in whole ticks via r_sec_cnt.
  always_comb begin
    w_state_d = r_state;
    w_nxt_d   = r_nxt;
    if (w_tick_now) begin
      case (r_state)
        MAIN_G: if (r_sec_cnt >= GM_LAST && (i_side_req || w_ped_pend)) w_state_d = MAIN_Y;
        MAIN_Y: if (r_sec_cnt == Y_LAST) begin
          w_state_d = ALL_RED;
          w_nxt_d   = w_ped_pend ? PED : SIDE_G;
        end
`ifdef TRAFFIC_PED_EN
        PED: if (r_sec_cnt == P_LAST) begin
          w_state_d = ALL_RED;
          w_nxt_d   = i_side_req ? SIDE_G : MAIN_G;
        end
`endif
        SIDE_G: if (r_sec_cnt == GS_LAST) w_state_d = SIDE_Y;
        SIDE_Y: if (r_sec_cnt == Y_LAST) begin
          w_state_d = ALL_RED;
          w_nxt_d   = MAIN_G;
        end
        ALL_RED: if (r_sec_cnt == AR_LAST) w_state_d = r_nxt;
        default: begin
          w_state_d = ALL_RED;
          w_nxt_d   = MAIN_G;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ALL_RED;
      r_nxt     <= MAIN_G;
      r_sec_cnt <= '0;
      r_lamps   <= RESET_LAMPS;
    end else begin
      r_state <= w_state_d;
      r_nxt   <= w_nxt_d;
      r_lamps <= lamps_of(w_state_d);
      if (w_tick_now) begin
        if (w_state_d != r_state) r_sec_cnt <= '0;
        else if (r_sec_cnt != 8'hFF) r_sec_cnt <= r_sec_cnt + 8'd1;
      end
    end
  end

`ifdef TRAFFIC_PED_EN
  logic w_enter_ped;
  logic r_ped_pend;
  logic r_ped_ack;

  assign w_enter_ped = (w_state_d == PED) && (r_state != PED);
  assign w_ped_pend  = r_ped_pend;
  assign o_ped_walk  = r_lamps.walk;
  assign o_ped_ack   = r_ped_ack;

  // A press sampled on the entry edge survives the clear and stays pending.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ped_pend <= 1'b0;
      r_ped_ack  <= 1'b0;
    end else begin
      r_ped_pend <= i_ped_req | (r_ped_pend & ~w_enter_ped);
      r_ped_ack  <= w_enter_ped;
    end
  end
`else
  logic w_unused_ped;
  assign w_unused_ped = i_ped_req ^ r_lamps.walk;
  assign w_ped_pend   = 1'b0;
  assign o_ped_walk   = 1'b0;
  assign o_ped_ack    = 1'b0;
`endif

  assign o_main_r = r_lamps.main_l.r;
  assign o_main_y = r_lamps.main_l.y;
  assign o_main_g = r_lamps.main_l.g;
  assign o_side_r = r_lamps.side_l.r;
  assign o_side_y = r_lamps.side_l.y;
  assign o_side_g = r_lamps.side_l.g;
  assign o_phase  = r_state;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase scheduler for a two-road intersection: main road, side road and an optional pedestrian crossing. It drives the red/yellow/green lamp outputs for both roads and the walk lamp, using a 1 s tick derived from the system clock. Main road rests on green. It yields only on a side-road vehicle request or a latched pedestrian request, with an all-red clearance interval between conflicting phases. The block sits between the sensor/button input synchronisers and the lamp driver outputs.

## Interface
- CLK_HZ, 24_000_000: system clock frequency; one tick every CLK_HZ cycles (TICK_DIV = CLK_HZ).
- GREEN_MAIN_S, 30: minimum main green, seconds.
- GREEN_SIDE_S, 15: fixed side green, seconds.
- YELLOW_S, 3: yellow duration, both roads.
- ALLRED_S, 2: all-red clearance duration.
- PED_S, 10: pedestrian walk duration.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- side_req  in  1  side-road vehicle present (level, pre-synchronised).
- ped_req  in  1  pedestrian button (pre-synchronised, any width pulse).
- main_r, main_y, main_g  out  1 each  main-road lamps.
- side_r, side_y, side_g  out  1 each  side-road lamps.
- ped_walk  out  1  walk lamp.
- ped_ack  out  1  one-cycle pulse when a pedestrian request is served.
- sec_tick  out  1  one-cycle 1 s strobe.
- phase  out  3  current state encoding, for debug.

## Operation
- States: MAIN_G, MAIN_Y, ALL_RED, PED, SIDE_G, SIDE_Y.
- ALL_RED carries a registered `nxt` target, chosen on entry.
- Transitions are evaluated only on sec_tick. A state lasting N seconds is exited on the tick where sec_cnt == N-1.
- MAIN_G -> MAIN_Y: requires GREEN_MAIN_S elapsed and (side_req or ped_pend) high at that tick.
  - With no request, MAIN_G holds indefinitely; sec_cnt saturates at 255.
  - A request arriving after the minimum has elapsed triggers the exit at the next tick.
- MAIN_Y -> ALL_RED after YELLOW_S. nxt = PED if ped_pend, else SIDE_G.
- PED -> ALL_RED after PED_S. nxt = SIDE_G if side_req, else MAIN_G.
- SIDE_G -> SIDE_Y after GREEN_SIDE_S, regardless of side_req.
- SIDE_Y -> ALL_RED after YELLOW_S, nxt = MAIN_G.
- ALL_RED -> nxt after ALLRED_S.
- ped_pend:
  - Set by ped_req high on any cycle.
  - Cleared on the cycle of entry to PED; that same cycle asserts ped_ack.
  - Set dominates clear, so a press during the PED entry cycle remains pending.
- Lamps are decoded from the state:
  - MAIN_G: main_g=1, side_r=1.
  - MAIN_Y: main_y=1, side_r=1.
  - SIDE_G: side_g=1, main_r=1.
  - SIDE_Y: side_y=1, main_r=1.
  - ALL_RED: main_r=1, side_r=1.
  - PED: main_r=1, side_r=1, ped_walk=1.
- Exactly one lamp per road is lit at all times. A green on one road never coincides with a non-red on the other.
- Widths:
  - Prescaler is $clog2(CLK_HZ) bits and wraps at CLK_HZ-1.
  - sec_cnt is 8 bits. All duration parameters must be in 1..255; elaboration fails otherwise.

## Timing
- Reset values:
  - State ALL_RED with nxt = MAIN_G.
  - main_r=1, side_r=1; all other lamps 0.
  - ped_walk=0, ped_ack=0, sec_tick=0, prescaler=0, sec_cnt=0, ped_pend=0.
  - phase = ALL_RED encoding.
- After reset release, sec_tick first fires CLK_HZ cycles later. The block leaves ALL_RED after ALLRED_S ticks.
- All outputs are registered and change on the same clock edge as the state register, with no extra latency.
- On a state change, sec_cnt resets to 0 on the tick edge. Each state therefore lasts exactly N*CLK_HZ cycles.
- Reset asserted mid-phase forces the reset state immediately (asynchronous) and discards any pending pedestrian request.

## Configuration
- TRAFFIC_PED_EN defined: pedestrian logic is present as described above.
- TRAFFIC_PED_EN undefined:
  - No PED state and no ped_pend register; ped_req is ignored.
  - ped_walk and ped_ack are tied to 0.
  - MAIN_G exits on side_req only, and MAIN_Y always targets SIDE_G.

## Structure
- Shared package traffic_pkg holds:
  - The phase_t state enum (3-bit, fixed encodings; the phase output uses them).
  - Lamp-bundle typedefs.
  - Default duration constants.
- Sub-module traffic_tick_gen: parameterised prescaler producing sec_tick. Reused by other timed blocks.

## Test plan
Bench uses CLK_HZ=4, GREEN_MAIN_S=3, GREEN_SIDE_S=2, YELLOW_S=1, ALLRED_S=1, PED_S=2.
- Reset, no requests for 200 cycles -> ALL_RED for 4 cycles, then MAIN_G held; main_g=1, side_r=1 throughout.
- side_req=1 held from cycle 0 -> sequence MAIN_G 12 cycles, MAIN_Y 4, ALL_RED 4, SIDE_G 8, SIDE_Y 4, ALL_RED 4, then MAIN_G.
- ped_req 1-cycle pulse during MAIN_G, side_req=0 -> MAIN_Y, ALL_RED, PED (ped_walk=1 for 8 cycles, ped_ack pulse at entry), ALL_RED, MAIN_G.
- ped_req pulse and side_req=1 together -> PED served first, then ALL_RED, then SIDE_G.
- ped_req pulse on the PED entry cycle -> ped_pend remains 1 and a second PED is served after the next MAIN_G minimum.
- reset low for 1 cycle during SIDE_G -> lamps immediately main_r=side_r=1, others 0, ped_pend=0; the sequence restarts.
